// File: rtl/sfp_link_pkg.sv
// Shared definitions for the SFP+ link sequencer: state codes, counter width,
// and the safe levels the input filters hold while in reset.
package sfp_link_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_RESET_PHY = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_UP        = 3'd3,
    ST_FAULT     = 3'd4,
    ST_HOLDOFF   = 3'd5
  } state_e;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic RST_LOS     = 1'b1;
  localparam logic RST_FAULT   = 1'b0;
  localparam logic RST_ALARM_B = 1'b0;
  localparam logic RST_LOCK    = 1'b0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output follows the synced
// input only after it has disagreed with the output for DEBOUNCE_CYC cycles in a row.
module sync_debounce
  import sfp_link_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = 1000,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_dout
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= RST_VAL;
      r_s2   <= RST_VAL;
      r_filt <= RST_VAL;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
      // Any cycle where the synced value agrees with the output restarts the count.
      if (r_s2 != r_filt) begin
        if (r_cnt == CNT_LAST) begin
          r_filt <= r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_dout = r_filt;

endmodule

// File: rtl/sfp_link_ctrl.sv
// Bring-up and supervision sequencer for one SFP+ port and its 10G PHY:
// filters module/PHY status, drives TX_DISABLE and PHY reset, retries until link is up.
module sfp_link_ctrl
  import sfp_link_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = 1000,
  parameter int PHY_RST_CYC      = 64,
  parameter int LOCK_TIMEOUT_CYC = 1000000,
  parameter int HOLDOFF_CYC      = 100000
) (
  input  logic             clk100,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             sfp_rx_los,
  input  logic             sfp_tx_fault,
  input  logic             sfp_clk_alarm_b,
  input  logic             pcs_block_lock,
  output logic             sfp_tx_disable,
  output logic             phy_rst,
  output logic             link_up,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] fault_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int TMR_MAX = max_i(max_i(DEBOUNCE_CYC, PHY_RST_CYC),
                                 max_i(LOCK_TIMEOUT_CYC, HOLDOFF_CYC));
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] LD_PHY  = TMR_W'(PHY_RST_CYC - 1);
  localparam logic [TMR_W-1:0] LD_LOCK = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] LD_HOLD = TMR_W'(HOLDOFF_CYC - 1);

  logic w_los_f;
  logic w_fault_f;
  logic w_alarm_b_f;
  logic w_lock_f;

  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(RST_LOS)) u_db_los (
    .clk(clk100), .rst_n(sys_rst_n), .i_din(sfp_rx_los), .o_dout(w_los_f)
  );
  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(RST_FAULT)) u_db_fault (
    .clk(clk100), .rst_n(sys_rst_n), .i_din(sfp_tx_fault), .o_dout(w_fault_f)
  );
  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(RST_ALARM_B)) u_db_alarm (
    .clk(clk100), .rst_n(sys_rst_n), .i_din(sfp_clk_alarm_b), .o_dout(w_alarm_b_f)
  );
  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(RST_LOCK)) u_db_lock (
    .clk(clk100), .rst_n(sys_rst_n), .i_din(pcs_block_lock), .o_dout(w_lock_f)
  );

  state_e            r_state;
  state_e            w_state_nxt;
  logic [TMR_W-1:0]  r_tmr;
  logic [TMR_W-1:0]  w_tmr_nxt;
  logic              w_tmr_zero;
  logic              w_drop_evt;
  logic              w_fault_evt;
  logic              r_tx_dis;
  logic              r_phy_rst;
  logic              r_link_up;
  logic              w_tx_dis_nxt;
  logic              w_phy_rst_nxt;
  logic              w_link_up_nxt;
  logic [CNT_W-1:0]  r_fault_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr;
    w_drop_evt    = 1'b0;
    w_fault_evt   = 1'b0;
    w_tx_dis_nxt  = 1'b1;
    w_phy_rst_nxt = 1'b1;
    w_link_up_nxt = 1'b0;
    w_tmr_zero    = (r_tmr == '0);

    // Admin disable and clock alarm override everything, then TX fault.
    if (!enable || !w_alarm_b_f) begin
      w_state_nxt = ST_DISABLED;
    end else if (w_fault_f && (r_state inside {ST_RESET_PHY, ST_WAIT_LOCK, ST_UP, ST_HOLDOFF})) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_DISABLED:  w_state_nxt = ST_RESET_PHY;
        ST_RESET_PHY: if (w_tmr_zero) w_state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (w_lock_f && !w_los_f) begin
            w_state_nxt = ST_UP;
          end else if (w_tmr_zero) begin
            w_state_nxt = ST_HOLDOFF;
            w_drop_evt  = 1'b1;
          end
        end
        ST_UP: begin
          if (w_los_f || !w_lock_f) begin
            w_state_nxt = ST_HOLDOFF;
            w_drop_evt  = 1'b1;
          end
        end
        ST_FAULT:     if (!w_fault_f) w_state_nxt = ST_HOLDOFF;
        ST_HOLDOFF:   if (w_tmr_zero) w_state_nxt = ST_RESET_PHY;
        default:      w_state_nxt = ST_DISABLED;
      endcase
    end

    w_fault_evt = (w_state_nxt == ST_FAULT) && (r_state != ST_FAULT);

    // The timer is reloaded on every state entry; DISABLED keeps it cleared.
    if (w_state_nxt == ST_DISABLED) begin
      w_tmr_nxt = '0;
    end else if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        ST_RESET_PHY: w_tmr_nxt = LD_PHY;
        ST_WAIT_LOCK: w_tmr_nxt = LD_LOCK;
        ST_HOLDOFF:   w_tmr_nxt = LD_HOLD;
        default:      w_tmr_nxt = '0;
      endcase
    end else if (!w_tmr_zero) begin
      w_tmr_nxt = r_tmr - TMR_W'(1);
    end

    case (w_state_nxt)
      ST_RESET_PHY: w_tx_dis_nxt = 1'b0;
      ST_WAIT_LOCK: begin
        w_tx_dis_nxt  = 1'b0;
        w_phy_rst_nxt = 1'b0;
      end
      ST_UP: begin
        w_tx_dis_nxt  = 1'b0;
        w_phy_rst_nxt = 1'b0;
        w_link_up_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk100 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_DISABLED;
      r_tmr       <= '0;
      r_tx_dis    <= 1'b1;
      r_phy_rst   <= 1'b1;
      r_link_up   <= 1'b0;
      r_fault_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_tx_dis  <= w_tx_dis_nxt;
      r_phy_rst <= w_phy_rst_nxt;
      r_link_up <= w_link_up_nxt;
      if (w_fault_evt) r_fault_cnt <= sat_inc(r_fault_cnt);
      if (w_drop_evt)  r_drop_cnt  <= sat_inc(r_drop_cnt);
    end
  end

  assign sfp_tx_disable = r_tx_dis;
  assign phy_rst        = r_phy_rst;
  assign link_up        = r_link_up;
  assign state          = r_state;
  assign fault_cnt      = r_fault_cnt;
  assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Directed bench for sfp_link_ctrl with short timing parameters: a vector table for
// bring-up and LOS filtering, then hand sequences for fault, retry saturation, disable and reset.
module tb_sfp_link_ctrl;

  logic       clk100 = 1'b0;
  logic       sys_rst_n;
  logic       enable;
  logic       sfp_rx_los;
  logic       sfp_tx_fault;
  logic       sfp_clk_alarm_b;
  logic       pcs_block_lock;
  logic       sfp_tx_disable;
  logic       phy_rst;
  logic       link_up;
  logic [2:0] state;
  logic [7:0] fault_cnt;
  logic [7:0] drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk100 = ~clk100;

  sfp_link_ctrl #(
    .DEBOUNCE_CYC(4), .PHY_RST_CYC(8), .LOCK_TIMEOUT_CYC(100), .HOLDOFF_CYC(20)
  ) dut (
    .clk100(clk100), .sys_rst_n(sys_rst_n), .enable(enable),
    .sfp_rx_los(sfp_rx_los), .sfp_tx_fault(sfp_tx_fault),
    .sfp_clk_alarm_b(sfp_clk_alarm_b), .pcs_block_lock(pcs_block_lock),
    .sfp_tx_disable(sfp_tx_disable), .phy_rst(phy_rst), .link_up(link_up),
    .state(state), .fault_cnt(fault_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int   cyc;
    logic en, los, flt, alm, lck;
    int   st, tx, phy, up, drop, fc;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input int st, input int tx, input int phy,
                         input int up, input int drop, input int fc);
    chk({tag, ".state"},      int'(state),          st);
    chk({tag, ".tx_disable"}, int'(sfp_tx_disable), tx);
    chk({tag, ".phy_rst"},    int'(phy_rst),        phy);
    chk({tag, ".link_up"},    int'(link_up),        up);
    chk({tag, ".drop_cnt"},   int'(drop_cnt),       drop);
    chk({tag, ".fault_cnt"},  int'(fault_cnt),      fc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  initial begin
    //            cyc en los flt alm lck   st tx phy up drop fc
    tbl[0]  = '{  6, 1, 0, 0, 1, 0,   0, 1, 1, 0, 0, 0};  // alarm_b_f just rose
    tbl[1]  = '{  1, 1, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0};  // enter RESET_PHY
    tbl[2]  = '{  7, 1, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0};  // 8th RESET_PHY cycle
    tbl[3]  = '{  1, 1, 0, 0, 1, 0,   2, 0, 0, 0, 0, 0};  // WAIT_LOCK
    tbl[4]  = '{  6, 1, 0, 0, 1, 1,   2, 0, 0, 0, 0, 0};  // lock_f just rose
    tbl[5]  = '{  1, 1, 0, 0, 1, 1,   3, 0, 0, 1, 0, 0};  // UP 7 cycles after lock
    tbl[6]  = '{  3, 1, 1, 0, 1, 1,   3, 0, 0, 1, 0, 0};  // 3-cycle LOS pulse
    tbl[7]  = '{  6, 1, 0, 0, 1, 1,   3, 0, 0, 1, 0, 0};  // pulse filtered out
    tbl[8]  = '{  6, 1, 1, 0, 1, 1,   3, 0, 0, 1, 0, 0};  // 6-cycle LOS, los_f just rose
    tbl[9]  = '{  1, 1, 0, 0, 1, 1,   5, 1, 1, 0, 1, 0};  // drop -> HOLDOFF
    tbl[10] = '{ 19, 1, 0, 0, 1, 1,   5, 1, 1, 0, 1, 0};  // last HOLDOFF cycle
    tbl[11] = '{  1, 1, 0, 0, 1, 1,   1, 0, 1, 0, 1, 0};  // retry RESET_PHY
    tbl[12] = '{  8, 1, 0, 0, 1, 1,   2, 0, 0, 0, 1, 0};  // WAIT_LOCK
    tbl[13] = '{  1, 1, 0, 0, 1, 1,   3, 0, 0, 1, 1, 0};  // back UP

    sys_rst_n       = 1'b0;
    enable          = 1'b1;
    sfp_rx_los      = 1'b0;
    sfp_tx_fault    = 1'b0;
    sfp_clk_alarm_b = 1'b1;
    pcs_block_lock  = 1'b0;
    tick(3);
    chk_all("reset", 0, 1, 1, 0, 0, 0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      enable          = tbl[i].en;
      sfp_rx_los      = tbl[i].los;
      sfp_tx_fault    = tbl[i].flt;
      sfp_clk_alarm_b = tbl[i].alm;
      pcs_block_lock  = tbl[i].lck;
      tick(tbl[i].cyc);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].tx, tbl[i].phy,
              tbl[i].up, tbl[i].drop, tbl[i].fc);
    end

    // TX fault while UP
    sfp_tx_fault = 1'b1;
    tick(6);
    chk_all("flt_pre", 3, 0, 0, 1, 1, 0);
    tick(1);
    chk_all("flt_in", 4, 1, 1, 0, 1, 1);
    tick(5);
    chk_all("flt_hold", 4, 1, 1, 0, 1, 1);
    sfp_tx_fault = 1'b0;
    tick(6);
    chk("flt_clr_pre.state", int'(state), 4);
    tick(1);
    chk_all("flt_holdoff", 5, 1, 1, 0, 1, 1);
    tick(20);
    chk("flt_rphy.state", int'(state), 1);
    tick(9);
    chk_all("flt_up", 3, 0, 0, 1, 1, 1);

    // Lock lost, then repeated lock timeouts up to saturation
    pcs_block_lock = 1'b0;
    tick(6);
    chk("lock_pre.state", int'(state), 3);
    tick(1);
    chk_all("lock_drop", 5, 1, 1, 0, 2, 1);
    tick(20);
    chk("retry1_rphy.state", int'(state), 1);
    tick(8);
    chk("retry1_wl.state", int'(state), 2);
    tick(99);
    chk_all("retry1_wl_end", 2, 0, 0, 0, 2, 1);
    tick(1);
    chk_all("retry1_to", 5, 1, 1, 0, 3, 1);
    tick(128 * 251);
    chk_all("retry252", 5, 1, 1, 0, 254, 1);
    tick(128);
    chk_all("retry253", 5, 1, 1, 0, 255, 1);
    tick(128 * 47);
    chk_all("retry300", 5, 1, 1, 0, 255, 1);

    // Enable dropped mid-WAIT_LOCK
    tick(28);
    tick(5);
    chk("dis_pre.state", int'(state), 2);
    enable = 1'b0;
    tick(1);
    chk_all("disabled", 0, 1, 1, 0, 255, 1);
    enable = 1'b1;
    tick(1);
    chk_all("reenable", 1, 0, 1, 0, 255, 1);
    tick(3);

    // Asynchronous reset mid-RESET_PHY, no clock edge in between
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 1, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
